serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial N-bit adder built around the team's single-bit full-adder equations: sum = a^b^c, carry = (a&b) | (c&(a^b)).
- Loads two operands and a carry-in on a start strobe, then processes one bit per clock, LSB first.
- The carry is held in a flip-flop between bits, and sum bits are collected in a shift register.
- Sits downstream of the full-adder cell, consuming its sum/carry each cycle. Serves as the area-cheap alternative to a ripple adder.

Parameters:
- WIDTH, 8: operand and sum width in bits, legal range 1..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin an addition; sampled only while idle (busy=0)
- a  input  WIDTH  operand A, captured on an accepted start
- b  input  WIDTH  operand B, captured on an accepted start
- cin  input  1  carry-in, captured on an accepted start
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse when sum/cout become valid
- sum  output  WIDTH  registered result, holds until the next completion
- cout  output  1  registered carry-out, holds until the next completion

Behaviour:
- Reset: one clock, clk; reset rst_n, asynchronous, active-low.
  - While rst_n=0: state=IDLE, busy=0, done=0, sum=0, cout=0.
  - Internal shift registers, carry flip-flop and bit counter are all 0.
- States: IDLE, SHIFT.
- IDLE:
  - On an edge with start=1: capture a into a_sr, b into b_sr, cin into the carry flip-flop.
  - Same edge: clear the bit counter, go to SHIFT, busy=1.
  - start=0: stay in IDLE.
- SHIFT, on each edge:
  - fs = a_sr[0]^b_sr[0]^carry; fc = (a_sr[0]&b_sr[0]) | (carry&(a_sr[0]^b_sr[0])).
  - s_sr <= {fs, s_sr[WIDTH-1:1]}; carry <= fc.
  - a_sr and b_sr shift right one bit, MSB filled with 0; counter increments.
- Completion: on the edge that processes bit WIDTH-1 (counter = WIDTH-1):
  - sum <= final shifted value, cout <= fc, done <= 1.
  - State returns to IDLE, busy <= 0.
- Latency: start accepted at edge k → done=1 and result valid in the cycle after edge k+WIDTH. Throughput is one addition per WIDTH+1 cycles.
- done is high for exactly one cycle and cleared on the following edge.
- sum/cout change only on a completion edge or on reset.
- start while busy=1 is ignored. Operands and cin are not re-sampled.
- start=1 in the cycle done=1: the FSM is already IDLE, so the new addition is accepted. done still drops next edge; sum/cout keep the old result until the new completion.
- a/b/cin changing during SHIFT have no effect.
- Arithmetic is modulo 2^WIDTH; the overflow bit appears only on cout. {cout,sum} = a + b + cin exactly.
- WIDTH=1: SHIFT lasts one cycle, which reduces the block to a registered full adder.
- Reset asserted mid-SHIFT: immediate abort. All outputs go to 0, no done pulse. After release, the next start begins cleanly.
- Counter width is max(1, clog2(WIDTH)); no wrap occurs because the exit happens at WIDTH-1.

Test Plan:
- WIDTH=8, a=0x5A, b=0x33, cin=0, start pulsed at edge k → busy=1 for edges k+1..k+8. done=1 exactly one cycle after edge k+8, with sum=0x8D, cout=0.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1. Then a=0, b=0, cin=0 → sum=0x00, cout=0.
- Start held high continuously with different operands while busy → only the first operands are used; result matches the first pair. A new operation begins only after done.
- start asserted in the done cycle with a=0x10, b=0x20 → accepted. Old sum is held until the new done, which reports sum=0x30, cout=0 WIDTH+1 cycles later.
- rst_n pulled low at the 4th SHIFT cycle → sum=0, cout=0, busy=0 immediately, no done. After release, a=0x80, b=0x80 → sum=0x00, cout=1.
- WIDTH=1, all 8 combinations of a, b, cin → {cout,sum} equals the full-adder truth table. Each done arrives two cycles after start.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder step per clock, LSB first.
// The carry lives in a flip-flop between bits and sum bits collect in a shift register.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    typedef enum logic [0:0] {
        StIdle,
        StShift
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] s_sr_q, s_sr_d;
    logic             carry_q, carry_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    // Full-adder cell on the current LSBs.
    logic             fs, fc;
    logic [WIDTH-1:0] s_shifted;

    assign fs = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    assign fc = (a_sr_q[0] & b_sr_q[0]) | (carry_q & (a_sr_q[0] ^ b_sr_q[0]));

    // A one-bit adder has no upper sum bits to shift down.
    if (WIDTH == 1) begin : g_w1
        assign s_shifted = fs;
    end else begin : g_wn
        assign s_shifted = {fs, s_sr_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        s_sr_d  = s_sr_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        done_d  = 1'b0;
        busy_d  = busy_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    s_sr_d  = '0;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = StShift;
                    busy_d  = 1'b1;
                end
            end
            StShift: begin
                s_sr_d  = s_shifted;
                carry_d = fc;
                a_sr_d  = a_sr_q >> 1;
                b_sr_d  = b_sr_q >> 1;
                cnt_d   = cnt_q + CntW'(1);
                if (cnt_q == LastBit) begin
                    sum_d   = s_shifted;
                    cout_d  = fc;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            s_sr_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            s_sr_q  <= s_sr_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Randomized self-checking bench for serial_adder at WIDTH=8 and WIDTH=1,
// checked against plain a+b+cin arithmetic.
module tb_serial_adder;

    logic clk;
    logic rst_n;

    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;

    logic start1, a1, b1, cin1, busy1, done1, sum1, cout1;

    int unsigned n_checks;
    int unsigned n_pass;

    // Reference state: the last completed result of the WIDTH=8 instance.
    logic [7:0] ref_sum;
    logic       ref_cout;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start8),
        .a    (a8),
        .b    (b8),
        .cin  (cin8),
        .busy (busy8),
        .done (done8),
        .sum  (sum8),
        .cout (cout8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start1),
        .a    (a1),
        .b    (b1),
        .cin  (cin1),
        .busy (busy1),
        .done (done1),
        .sum  (sum1),
        .cout (cout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Called at a negedge. Launches one addition and follows it to its done cycle,
    // returning at the negedge of that cycle. keep_start holds start high with
    // fresh random operands throughout the busy period.
    task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                        input bit keep_start);
        logic [8:0] total;
        total  = 9'(ta) + 9'(tb) + 9'(tc);
        a8     = ta;
        b8     = tb;
        cin8   = tc;
        start8 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (!keep_start) begin
                start8 = 1'b0;
                a8     = 8'($urandom);
                b8     = 8'($urandom);
            end else begin
                a8   = 8'($urandom);
                b8   = 8'($urandom);
                cin8 = 1'($urandom);
            end
            check("busy8_high", 64'(busy8), 64'd1);
            check("done8_low", 64'(done8), 64'd0);
            check("sum8_held", {55'd0, cout8, sum8}, {55'd0, ref_cout, ref_sum});
        end
        @(negedge clk);
        ref_sum  = total[7:0];
        ref_cout = total[8];
        check("done8_pulse", 64'(done8), 64'd1);
        check("busy8_low", 64'(busy8), 64'd0);
        check("sum8", 64'(sum8), 64'(ref_sum));
        check("cout8", 64'(cout8), 64'(ref_cout));
    endtask

    task automatic idle8();
        start8 = 1'b0;
        @(negedge clk);
        check("done8_drop", 64'(done8), 64'd0);
        check("busy8_idle", 64'(busy8), 64'd0);
        check("sum8_keep", {55'd0, cout8, sum8}, {55'd0, ref_cout, ref_sum});
    endtask

    initial begin
        logic [2:0] combo;
        logic [1:0] fa;
        n_checks = 0;
        n_pass   = 0;
        ref_sum  = '0;
        ref_cout = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;

        rst_n = 1'b0;
        #1;
        check("rst_outputs8", {52'd0, busy8, done8, cout8, sum8}, 64'd0);
        check("rst_outputs1", {60'd0, busy1, done1, cout1, sum1}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases.
        run8(8'h5A, 8'h33, 1'b0, 1'b0); idle8();
        run8(8'hFF, 8'h01, 1'b0, 1'b0); idle8();
        run8(8'hFF, 8'hFF, 1'b1, 1'b0); idle8();
        run8(8'h00, 8'h00, 1'b0, 1'b0); idle8();

        // start held through the busy period: only the first operands count, and the
        // operands present in the done cycle launch the next addition.
        run8(8'hC3, 8'h7E, 1'b1, 1'b1);
        run8(a8, b8, cin8, 1'b0);
        // start in the done cycle is accepted immediately.
        run8(8'h10, 8'h20, 1'b0, 1'b0);
        idle8();

        // Reset in the 4th SHIFT cycle aborts without a done pulse.
        a8 = 8'h3C; b8 = 8'h5D; cin8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        ref_sum  = '0;
        ref_cout = 1'b0;
        check("abort_outputs", {52'd0, busy8, done8, cout8, sum8}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("abort_no_done", {62'd0, done8, busy8}, 64'd0);
        end
        run8(8'h80, 8'h80, 1'b0, 1'b0); idle8();

        // Random operands, some back-to-back from the done cycle.
        for (int n = 0; n < 24; n++) begin
            run8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
            if ($urandom_range(0, 1) == 0) idle8();
        end
        idle8();

        // WIDTH=1: a registered full adder, done two cycles after start.
        for (int i = 0; i < 8; i++) begin
            combo  = 3'(i);
            a1     = combo[2];
            b1     = combo[1];
            cin1   = combo[0];
            start1 = 1'b1;
            fa     = 2'(combo[2]) + 2'(combo[1]) + 2'(combo[0]);
            @(negedge clk);
            start1 = 1'b0;
            a1     = ~a1;
            check("w1_busy", {62'd0, busy1, done1}, 64'd2);
            @(negedge clk);
            check("w1_done", 64'(done1), 64'd1);
            check("w1_result", {62'd0, cout1, sum1}, 64'(fa));
            @(negedge clk);
            check("w1_drop", {62'd0, busy1, done1}, 64'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
